// File: rtl/sub_sched2.sv
`default_nettype none
// ============================================================================
// Module   : sub_sched2 (with helper sub_sched2_rca)
// Purpose  : Round-robin scheduler that serves two requesters on a single
//            shared N-bit ripple subtractor. Each 2N-bit subtraction runs as
//            two passes (low half, then high half with the carry chained in).
//            The result is held in an output register until it is accepted.
// Ports    : clk, rst                          clock, async active-high reset
//            req{0,1}_valid/ready/a/b          requester handshakes, 2N operands
//            res_valid/ready                   result handshake
//            res_diff, res_borrow, res_ovf     a-b, unsigned borrow, signed ovf
//            res_id                            requester that issued the result
//            busy                              any state other than IDLE
// Revision : 1.0 - initial release
// ============================================================================

// N-bit ripple subtractor: o_diff = i_a + ~i_b + i_c_in
module sub_sched2_rca #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c_in,
    output logic [N-1:0] o_diff,
    output logic         o_c_out
);
    logic [N:0] w_c;

    assign w_c[0] = i_c_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic w_nb;
        logic w_p;
        assign w_nb        = ~i_b[i];
        assign w_p         = i_a[i] ^ w_nb;
        assign o_diff[i]   = w_p ^ w_c[i];
        assign w_c[i+1]    = (i_a[i] & w_nb) | (w_p & w_c[i]);
    end

    assign o_c_out = w_c[N];
endmodule

module sub_sched2 #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [2*N-1:0] req0_a,
    input  logic [2*N-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [2*N-1:0] req1_a,
    input  logic [2*N-1:0] req1_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res_diff,
    output logic           res_borrow,
    output logic           res_ovf,
    output logic           res_id,
    output logic           busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [1:0]     w_next_state;

    logic           r_ptr;
    logic           r_id;
    logic [2*N-1:0] r_a;
    logic [2*N-1:0] r_b;
    logic [N-1:0]   r_diff_lo;
    logic [N-1:0]   r_diff_hi;
    logic           r_carry;
    logic           r_borrow;
    logic           r_ovf;

    logic           w_grant;
    logic           w_hs;
    logic [N-1:0]   w_sub_a;
    logic [N-1:0]   w_sub_b;
    logic           w_sub_cin;
    logic [N-1:0]   w_sub_diff;
    logic           w_sub_cout;

    // On a tie the pointer decides; otherwise the only valid requester wins.
    // With nobody valid the grant value is irrelevant since ready is gated by valid.
    assign w_grant = (req0_valid && req1_valid) ? r_ptr : req1_valid;
    assign w_hs    = req0_ready | req1_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_next_state = S_LO;
            S_LO:    w_next_state = S_HI;
            S_HI:    w_next_state = S_DONE;
            S_DONE:  if (res_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath-control logic
    // ------------------------------------------------------------------
    always_comb begin
        // Ready is held low while reset is asserted so all outputs read 0.
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        w_sub_a    = r_a[N-1:0];
        w_sub_b    = r_b[N-1:0];
        w_sub_cin  = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy       = 1'b0;
                req0_ready = ~rst & ~w_grant & req0_valid;
                req1_ready = ~rst &  w_grant & req1_valid;
            end
            S_HI: begin
                w_sub_a   = r_a[2*N-1:N];
                w_sub_b   = r_b[2*N-1:N];
                w_sub_cin = r_carry;
            end
            S_DONE: begin
                res_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    sub_sched2_rca #(.N(N)) u_sub (
        .i_a     (w_sub_a),
        .i_b     (w_sub_b),
        .i_c_in  (w_sub_cin),
        .o_diff  (w_sub_diff),
        .o_c_out (w_sub_cout)
    );

    // ------------------------------------------------------------------
    // Operand capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= 1'b0;
            r_id      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_diff_lo <= '0;
            r_diff_hi <= '0;
            r_carry   <= 1'b0;
            r_borrow  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_hs) begin
                r_a   <= w_grant ? req1_a : req0_a;
                r_b   <= w_grant ? req1_b : req0_b;
                r_id  <= w_grant;
                r_ptr <= ~w_grant;
            end
            if (r_state == S_LO) begin
                r_diff_lo <= w_sub_diff;
                r_carry   <= w_sub_cout;
            end
            if (r_state == S_HI) begin
                r_diff_hi <= w_sub_diff;
                r_borrow  <= ~w_sub_cout;
                // Signed overflow: operand signs differ and result sign differs from a.
                r_ovf     <= (r_a[2*N-1] ^ r_b[2*N-1]) & (w_sub_diff[N-1] ^ r_a[2*N-1]);
            end
        end
    end

    assign res_diff   = {r_diff_hi, r_diff_lo};
    assign res_borrow = r_borrow;
    assign res_ovf    = r_ovf;
    assign res_id     = r_id;

endmodule
`default_nettype wire
